// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants for the RV32M multiply/divide unit.
//   - OP_*  : funct3 encodings for MUL..REMU. The instruction decoder uses these too.
//   - S_*   : FSM state encodings for muldiv_unit.
//   - neg32 : conditional two's-complement helper.
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    function automatic logic [31:0] neg32(input logic n, input logic [31:0] v);
        return n ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one radix-2 step per cycle.
//   clk_i   in   rising-edge clock
//   reset_i in   async active-low reset
//   src1    in   [31:0] rs1 (multiplicand / dividend)
//   src2    in   [31:0] rs2 (multiplier / divisor)
//   op      in   [2:0]  funct3 (MUL..REMU)
//   start   in   request, sampled only in IDLE
//   flush   in   abort, forces IDLE at next edge
//   busy    out  high in CALC and DONE
//   done    out  one-cycle result-valid pulse (DONE state)
//   result  out  [31:0] registered result, held until the next DONE
// Operands are reduced to magnitudes at capture time. The sign is applied
// once, when the last iteration writes the result.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic [2:0]  op,
    input  logic        start,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [64:0] acc;      // mul: {carry, product}; div: {remainder, dividend/quotient}
    logic [31:0] opnd;     // multiplicand or divisor magnitude
    logic [2:0]  op_q;
    logic        neg_q;

    // ---- capture-time decode ----
    logic        sgn_a, sgn_b, na, nb, neg_res, spec;
    logic [31:0] mag_a, mag_b, spec_val;

    always_comb begin
        sgn_a   = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
                  (op == OP_DIV) || (op == OP_REM);
        sgn_b   = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        na      = sgn_a & src1[31];
        nb      = sgn_b & src2[31];
        mag_a   = neg32(na, src1);
        mag_b   = neg32(nb, src2);
        // Remainder takes the dividend's sign; everything else takes the XOR.
        neg_res = (op == OP_REM) ? na : (na ^ nb);

        spec     = 1'b0;
        spec_val = 32'd0;
        if (op[2]) begin
            if (src2 == 32'd0) begin
                spec     = 1'b1;
                spec_val = op[1] ? src1 : 32'hFFFF_FFFF;
            end else if (((op == OP_DIV) || (op == OP_REM)) &&
                         (src1 == 32'h8000_0000) && (src2 == 32'hFFFF_FFFF)) begin
                spec     = 1'b1;
                spec_val = op[1] ? 32'd0 : 32'h8000_0000;
            end
        end else if ((src1 == 32'd0) || (src2 == 32'd0)) begin
            spec     = 1'b1;
            spec_val = 32'd0;
        end
    end

    // ---- one iteration ----
    logic [32:0] psum;
    logic [64:0] shl;
    logic [33:0] diff;
    logic [64:0] acc_nxt;

    always_comb begin
        // Multiply: conditional add into the upper half, then shift right.
        psum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        // Divide: shift left, then trial-subtract the divisor from the upper part.
        shl  = {acc[63:0], 1'b0};
        diff = {acc[64], shl[64:32]} - {2'b00, opnd};
        if (!op_q[2])
            acc_nxt = {1'b0, psum, acc[31:1]};
        else if (!diff[33])
            acc_nxt = {diff[32:0], shl[31:1], 1'b1};
        else
            acc_nxt = shl;
    end

    // ---- final result from the last iteration ----
    logic [63:0] prod;
    logic [31:0] fin;

    always_comb begin
        prod = neg_q ? (64'd0 - acc_nxt[63:0]) : acc_nxt[63:0];
        case (op_q)
            OP_MUL:                        fin = prod[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fin = prod[63:32];
            OP_DIV, OP_DIVU:               fin = neg32(neg_q, acc_nxt[31:0]);
            default:                       fin = neg32(neg_q, acc_nxt[63:32]);
        endcase
    end

    // ---- FSM + datapath registers ----
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state  <= S_IDLE;
            cnt    <= 5'd0;
            acc    <= 65'd0;
            opnd   <= 32'd0;
            op_q   <= OP_MUL;
            neg_q  <= 1'b0;
            result <= 32'd0;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    op_q  <= op;
                    neg_q <= neg_res;
                    cnt   <= 5'd0;
                    if (spec) begin
                        result <= spec_val;
                        state  <= S_DONE;
                    end else begin
                        opnd  <= op[2] ? mag_b : mag_a;
                        acc   <= {33'd0, op[2] ? mag_a : mag_b};
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        result <= fin;
                        state  <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_CALC) || (state == S_DONE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with a scoreboard. Stimulus pushes
// {expected result, expected done cycle}. The monitor pops one entry on every
// done and compares both fields. A done with an empty queue is an error.
module tb_muldiv_unit;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [31:0] src1, src2;
    logic [2:0]  op;
    logic        start, flush;
    logic        busy, done;
    logic [31:0] result;

    muldiv_unit dut (
        .clk_i(clk_i), .reset_i(reset_i), .src1(src1), .src2(src2), .op(op),
        .start(start), .flush(flush), .busy(busy), .done(done), .result(result)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] res;
        int          cyc;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] last_res = 32'd0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor
    always @(negedge clk_i) begin
        if (reset_i && done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_result"}, result, e.res);
                check({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
                last_res = e.res;
            end
        end
    end

    // Called just after a negedge: drives a one-cycle start pulse.
    task automatic drive(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; src1 = a; src2 = b; start = 1'b1;
        @(negedge clk_i);
        start = 1'b0;
    endtask

    task automatic issue(input string nm, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
        exp_t e;
        e.res = exp; e.cyc = cyc + lat; e.name = nm;
        sb.push_back(e);
        drive(o, a, b);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk_i);
        while ((busy || sb.size() != 0) && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idle_timeout: busy=%b pending=%0d", busy, sb.size());
            sb.delete();
        end
    endtask

    task automatic run(input string nm, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
        issue(nm, o, a, b, exp, lat);
        wait_idle();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i = 1'b0; start = 1'b0; flush = 1'b0;
        op = 3'd0; src1 = 32'd0; src2 = 32'd0;
        #12;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        @(negedge clk_i);
        reset_i = 1'b1;

        // First edge after reset accepts the request.
        run("mul_7_m3",    3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run("mulhu_max",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run("mulh_m1_m1",  3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
        run("mulhsu_m1_2", 3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33);
        run("mulh_min_sq", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        run("div_m7_2",    3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
        run("rem_m7_2",    3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
        run("divu_100_7",  3'b101, 32'd100,       32'd7,         32'd14,        33);
        run("remu_100_7",  3'b111, 32'd100,       32'd7,         32'd2,         33);
        run("div_min_2",   3'b100, 32'h8000_0000, 32'd2,         32'hC000_0000, 33);
        run("divu_by0",    3'b101, 32'd100,       32'd0,         32'hFFFF_FFFF, 1);
        run("remu_by0",    3'b111, 32'd100,       32'd0,         32'd100,       1);
        run("div_by0",     3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        run("rem_m5_by0",  3'b110, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1);
        run("div_ovf",     3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run("rem_ovf",     3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
        run("mul_zero",    3'b000, 32'd0,         32'd5,         32'd0,         1);
        run("mulhu_zero",  3'b011, 32'hFFFF_FFFF, 32'd0,         32'd0,         1);

        // start held through the DONE cycle: only one operation runs.
        begin
            exp_t e;
            e.res = 32'hFFFF_FFFF; e.cyc = cyc + 1; e.name = "hold_start";
            sb.push_back(e);
            op = 3'b101; src1 = 32'd100; src2 = 32'd0; start = 1'b1;
            @(negedge clk_i);
            @(negedge clk_i);
            start = 1'b0;
            wait_idle();
        end

        // start mid-CALC is ignored (would give a 1-cycle zero result).
        issue("divu_midstart", 3'b101, 32'd100, 32'd7, 32'd14, 33);
        repeat (5) @(negedge clk_i);
        drive(3'b000, 32'd0, 32'd9);
        wait_idle();
        run("after_midstart", 3'b011, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 33);

        // flush 10 cycles after start: abort, no done, result held.
        drive(3'b000, 32'd3, 32'd5);
        repeat (9) @(negedge clk_i);
        flush = 1'b1;
        @(negedge clk_i);
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_result", result, last_res);
        repeat (40) @(negedge clk_i);
        check("flush_no_resume", {31'd0, busy}, 32'd0);
        run("after_flush", 3'b000, 32'd3, 32'd5, 32'd15, 33);

        // start and flush together in IDLE: nothing captured.
        op = 3'b101; src1 = 32'd1; src2 = 32'd0; start = 1'b1; flush = 1'b1;
        @(negedge clk_i);
        start = 1'b0; flush = 1'b0;
        check("flush_start_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk_i);

        // Reset mid-CALC.
        drive(3'b001, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (10) @(negedge clk_i);
        #2 reset_i = 1'b0;
        #1;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_done", {31'd0, done}, 32'd0);
        check("rst_mid_result", result, 32'd0);
        @(negedge clk_i);
        reset_i = 1'b1;
        last_res = 32'd0;
        run("after_reset", 3'b110, 32'd100, 32'hFFFF_FFF9, 32'd2, 33);
        repeat (40) @(negedge clk_i);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Port: clk_i  input  1  rising-edge clock for all state.
REQ-003 Port: reset_i  input  1  asynchronous, active-low reset.
REQ-004 Port: src1  input  32  operand rs1 (dividend or multiplicand).
REQ-005 Port: src2  input  32  operand rs2 (divisor or multiplier).
REQ-006 Port: op  input  3  RV32M funct3 encoding.
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 Port: start  input  1  request; sampled only in IDLE.
REQ-008 Port: flush  input  1  abort any operation in flight.
REQ-009 Port: busy  output  1  high in CALC and DONE.
REQ-010 Port: done  output  1  single-cycle result-valid pulse.
REQ-011 Port: result  output  32  operation result.

Function
REQ-012 The state machine SHALL have three states: IDLE, CALC and DONE.
REQ-013 In IDLE with start=1, the block SHALL capture src1, src2 and op at the clock edge.
REQ-014 On that capture, the block SHALL go to DONE if a special case applies (REQ-019 to REQ-021), and to CALC otherwise.
REQ-015 CALC SHALL run exactly 32 iterations with one radix-2 step per cycle.
  - Multiply: shift-add on operand magnitudes into a 64-bit accumulator.
  - Divide: restoring shift-subtract on operand magnitudes.
REQ-016 After the 32nd iteration, CALC SHALL go to DONE, and DONE SHALL go to IDLE on the next edge.
REQ-017 done SHALL be 1 only in DONE.
  - Normal latency: start edge to done-high cycle = 33 cycles.
  - Special cases: 1 cycle.
REQ-018 Sign handling:
  - MUL, MULH and DIV/REM: both operands signed.
  - MULHSU: src1 signed, src2 unsigned.
  - MULHU, DIVU and REMU: both operands unsigned.
  - Product sign = XOR of operand signs.
  - Quotient sign = XOR of operand signs; remainder sign = dividend sign.
  - The result SHALL be negated once, in the final iteration.
REQ-019 Divide by zero:
  - DIV and DIVU SHALL return 0xFFFFFFFF.
  - REM and REMU SHALL return src1.
REQ-020 Signed overflow (DIV with src1=0x80000000, src2=0xFFFFFFFF) SHALL return 0x80000000; REM in the same case SHALL return 0.
REQ-021 MUL/MULH* with either operand equal to 0 SHALL return 0.
REQ-022 Result selection:
  - MUL returns product bits [31:0].
  - MULH, MULHSU and MULHU return bits [63:32].
  - All results are exact 32-bit values with wrap-around modulo 2^32.
REQ-023 result SHALL be registered, SHALL update only on entry to DONE, and SHALL hold until the next DONE.
REQ-024 start while busy=1 SHALL be ignored; no queuing.
REQ-025 flush=1 in any state SHALL force IDLE at the next edge.
  - done SHALL not assert for the aborted operation.
  - result SHALL be unchanged.
  - flush has priority over start and over the CALC-to-DONE transition.
REQ-026 start and flush high together in IDLE SHALL be treated as flush; nothing is captured.
REQ-027 A start arriving in the same cycle done=1 SHALL be ignored; the next request is accepted one cycle later, in IDLE.

Reset
REQ-028 On reset_i=0, the block SHALL enter IDLE asynchronously.
  - busy=0, done=0, result=0x00000000.
  - Iteration counter and accumulators cleared.
REQ-029 Reset asserted mid-operation SHALL discard the operation with no done pulse.
REQ-030 The first start SHALL be accepted on the first rising edge after reset_i deasserts.

Structure
REQ-031 The op encodings (MUL..REMU) and the state encodings SHALL be defined as constants in a shared package, muldiv_pkg, also used by the decoder.
REQ-032 No sub-module is required; datapath and FSM SHALL reside in muldiv_unit.
REQ-033 The iteration counter SHALL be 5 bits, and the accumulator SHALL be 64 bits plus 1 carry bit.

Verification
REQ-034 MUL with src1=7, src2=0xFFFFFFFD (-3) -> result 0xFFFFFFEB, done exactly 33 cycles after the start edge.
REQ-035 Signed and unsigned high-word multiply:
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULH with the same operands -> 0x00000000.
REQ-036 Signed division rounding:
  - DIV -7/2 -> 0xFFFFFFFD.
  - REM -7/2 -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14.
  - REMU 100/7 -> 2.
REQ-037 Special cases, each with done one cycle after start:
  - DIVU 100/0 -> 0xFFFFFFFF; REMU 100/0 -> 100.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
REQ-038 Abort and back-to-back requests:
  - flush 10 cycles after start -> busy=0 next cycle, no done, result unchanged.
  - A start pulse mid-CALC is ignored.
  - A new start in IDLE is accepted.
REQ-039 reset_i pulsed low mid-CALC -> busy, done and result all 0 immediately, with no done pulse afterwards.
